// File: rtl/stream_packer_pkg.sv
// stream_packer_pkg
//   Shared definitions for the stream packer and neighbouring wide-port blocks:
//   packer state encodings and the lane-offset helper.
//   No ports (package).
package stream_packer_pkg;

    typedef logic [0:0] state_t;

    // Encodings stay fixed so they match the existing fifo-side blocks.
    localparam state_t ST_FILL = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

    // Bit offset of lane 'lane' in a packed word of 'width'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/stream_packer_if.sv
// stream_packer_if
//   Bundles the narrow input stream and the packed output stream of the packer.
//   Signals:
//     data_i / data_i_valid / data_i_last / data_i_ready   narrow word stream
//     data_o / data_o_mask / data_o_last / data_o_valid / data_o_ready   packed stream
//   Modports:
//     slave   the packer (consumes data_i, produces data_o)
//     master  the environment (produces data_i, consumes data_o)
interface stream_packer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PACK_RATIO = 4
);
    import stream_packer_pkg::*;

    localparam int unsigned OUT_WIDTH = DATA_WIDTH * PACK_RATIO;

    logic [DATA_WIDTH-1:0] data_i;
    logic                  data_i_valid;
    logic                  data_i_ready;
    logic                  data_i_last;
    logic [OUT_WIDTH-1:0]  data_o;
    logic [PACK_RATIO-1:0] data_o_mask;
    logic                  data_o_last;
    logic                  data_o_valid;
    logic                  data_o_ready;

    modport slave (
        input  data_i, data_i_valid, data_i_last, data_o_ready,
        output data_i_ready, data_o, data_o_mask, data_o_last, data_o_valid
    );

    modport master (
        output data_i, data_i_valid, data_i_last, data_o_ready,
        input  data_i_ready, data_o, data_o_mask, data_o_last, data_o_valid
    );

endinterface

// File: rtl/stream_packer.sv
// stream_packer
//   Packs PACK_RATIO consecutive narrow words into one wide word with a lane
//   mask. A packet is closed early when data_i_last is accepted. Sustains one
//   input word per cycle, including the cycle in which a full packet drains.
//   Ports:
//     clk        clock, rising edge
//     nreset_i   asynchronous, active-low reset
//     bus        stream_packer_if.slave (narrow input stream, packed output stream)
module stream_packer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PACK_RATIO = 4
) (
    input  logic            clk,
    input  logic            nreset_i,
    stream_packer_if.slave  bus
);
    import stream_packer_pkg::*;

    localparam int unsigned OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
    localparam int unsigned CNT_WIDTH = $clog2(PACK_RATIO);
    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(PACK_RATIO - 1);

    state_t                state_q, state_n;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_n;
    logic [OUT_WIDTH-1:0]  data_q, data_n;
    logic [PACK_RATIO-1:0] mask_q, mask_n;
    logic                  last_q, last_n;
    logic [PACK_RATIO-1:0] lane_we;
    logic                  out_valid;
    logic                  accept;
    logic                  drain;

    assign out_valid = (state_q == ST_HOLD);

    assign bus.data_i_ready = ~out_valid | bus.data_o_ready;
    assign accept           = bus.data_i_valid & bus.data_i_ready;
    assign drain            = out_valid & bus.data_o_ready;

    // cnt is always 0 in HOLD, so the same decode picks lane 0 for a word
    // accepted in the drain cycle.
    for (genvar k = 0; k < PACK_RATIO; k++) begin : g_lane_we
        assign lane_we[k] = accept & (cnt_q == CNT_WIDTH'(k));
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        last_n  = last_q;
        data_n  = data_q;
        mask_n  = mask_q;

        // A drain clears every lane; a lane written in the same cycle wins.
        for (int unsigned k = 0; k < PACK_RATIO; k++) begin
            if (lane_we[k]) begin
                data_n[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = bus.data_i;
                mask_n[k] = 1'b1;
            end else if (drain) begin
                data_n[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = '0;
                mask_n[k] = 1'b0;
            end
        end

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (cnt_q == LAST_LANE || bus.data_i_last) begin
                        state_n = ST_HOLD;
                        last_n  = bus.data_i_last;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (drain) begin
                    if (accept && bus.data_i_last) begin
                        // Single-word packet closed in the drain cycle.
                        state_n = ST_HOLD;
                        last_n  = 1'b1;
                        cnt_n   = '0;
                    end else if (accept) begin
                        state_n = ST_FILL;
                        last_n  = 1'b0;
                        cnt_n   = CNT_WIDTH'(1);
                    end else begin
                        state_n = ST_FILL;
                        last_n  = 1'b0;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            mask_q  <= mask_n;
            last_q  <= last_n;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.data_o_mask  = mask_q;
    assign bus.data_o_last  = last_q;
    assign bus.data_o_valid = out_valid;

endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer
//   Directed, table-driven bench for stream_packer (DATA_WIDTH=32, PACK_RATIO=4).
//   Each vector gives the inputs for one cycle, the expected data_i_ready in
//   that cycle and the expected registered outputs after the clock edge.
module tb_stream_packer;

    logic clk;
    logic nreset_i;

    stream_packer_if #(.DATA_WIDTH(32), .PACK_RATIO(4)) bus ();

    stream_packer #(.DATA_WIDTH(32), .PACK_RATIO(4)) dut (
        .clk      (clk),
        .nreset_i (nreset_i),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic         last;
        logic [31:0]  din;
        logic         ordy;
        logic         exp_iready;
        logic         exp_ovalid;
        logic [127:0] exp_data;
        logic [3:0]   exp_mask;
        logic         exp_last;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(logic v, logic l, logic [31:0] d, logic r,
                                logic ei, logic ev, logic [127:0] ed,
                                logic [3:0] em, logic el);
        vec_t t;
        t.valid = v; t.last = l; t.din = d; t.ordy = r;
        t.exp_iready = ei; t.exp_ovalid = ev; t.exp_data = ed;
        t.exp_mask = em; t.exp_last = el;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        bus.data_i_valid = v.valid;
        bus.data_i_last  = v.last;
        bus.data_i       = v.din;
        bus.data_o_ready = v.ordy;
        #1;
        chk({tag, ".iready"}, 128'(bus.data_i_ready), 128'(v.exp_iready));
        @(posedge clk);
        #1;
        chk({tag, ".ovalid"}, 128'(bus.data_o_valid), 128'(v.exp_ovalid));
        chk({tag, ".data"},   bus.data_o,             v.exp_data);
        chk({tag, ".mask"},   128'(bus.data_o_mask),  128'(v.exp_mask));
        chk({tag, ".last"},   128'(bus.data_o_last),  128'(v.exp_last));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".ovalid"}, 128'(bus.data_o_valid), 128'(0));
        chk({tag, ".data"},   bus.data_o,             128'(0));
        chk({tag, ".mask"},   128'(bus.data_o_mask),  128'(0));
        chk({tag, ".last"},   128'(bus.data_o_last),  128'(0));
        chk({tag, ".iready"}, 128'(bus.data_i_ready), 128'(1));
    endtask

    vec_t         idle;
    logic [127:0] ed;
    logic [4:0]   em;
    logic [127:0] pkt;

    initial begin
        idle = mk(0, 0, 32'h0, 1, 1, 0, 128'h0, 4'b0000, 0);

        // Four words back to back, then the packet drains.
        vecs.push_back(mk(1, 0, 32'h11, 1, 1, 0, 128'h00000011, 4'b0001, 0));
        vecs.push_back(mk(1, 0, 32'h22, 1, 1, 0, 128'h00000022_00000011, 4'b0011, 0));
        vecs.push_back(mk(1, 0, 32'h33, 1, 1, 0, 128'h00000033_00000022_00000011, 4'b0111, 0));
        vecs.push_back(mk(1, 0, 32'h44, 1, 1, 1, 128'h00000044_00000033_00000022_00000011, 4'b1111, 0));
        vecs.push_back(idle);

        // Twelve words streamed continuously: a packet every fourth cycle.
        for (int i = 0; i < 12; i++) begin
            int lane;
            lane = i % 4;
            ed = '0;
            for (int j = 0; j <= lane; j++) ed[j*32 +: 32] = 32'h100 + 32'(i - lane + j);
            em = (5'd1 << (lane + 1)) - 5'd1;
            vecs.push_back(mk(1, 0, 32'h100 + 32'(i), 1, 1, (lane == 3), ed, em[3:0], 0));
        end
        vecs.push_back(idle);

        // Partial packet closed by last on the second word.
        vecs.push_back(mk(1, 0, 32'hA, 1, 1, 0, 128'h0000000A, 4'b0001, 0));
        vecs.push_back(mk(1, 1, 32'hB, 1, 1, 1, 128'h0000000B_0000000A, 4'b0011, 1));
        vecs.push_back(idle);

        // last without valid is ignored.
        vecs.push_back(mk(0, 1, 32'hDEAD, 1, 1, 0, 128'h0, 4'b0000, 0));

        // Single word with last.
        vecs.push_back(mk(1, 1, 32'h77, 1, 1, 1, 128'h00000077, 4'b0001, 1));
        vecs.push_back(idle);

        // last on the final lane, then last on a word accepted in the drain cycle.
        vecs.push_back(mk(1, 0, 32'h1, 1, 1, 0, 128'h00000001, 4'b0001, 0));
        vecs.push_back(mk(1, 0, 32'h2, 1, 1, 0, 128'h00000002_00000001, 4'b0011, 0));
        vecs.push_back(mk(1, 0, 32'h3, 1, 1, 0, 128'h00000003_00000002_00000001, 4'b0111, 0));
        vecs.push_back(mk(1, 1, 32'h4, 1, 1, 1, 128'h00000004_00000003_00000002_00000001, 4'b1111, 1));
        vecs.push_back(mk(1, 1, 32'h99, 1, 1, 1, 128'h00000099, 4'b0001, 1));
        vecs.push_back(idle);

        bus.data_i       = '0;
        bus.data_i_valid = 1'b0;
        bus.data_i_last  = 1'b0;
        bus.data_o_ready = 1'b0;
        nreset_i         = 1'b0;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        nreset_i = 1'b1;

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: packet held for five cycles, then drain plus accept.
        pkt = 128'h00000204_00000203_00000202_00000201;
        step(mk(1, 0, 32'h201, 0, 1, 0, 128'h00000201, 4'b0001, 0), "bp.w0");
        step(mk(1, 0, 32'h202, 0, 1, 0, 128'h00000202_00000201, 4'b0011, 0), "bp.w1");
        step(mk(1, 0, 32'h203, 0, 1, 0, 128'h00000203_00000202_00000201, 4'b0111, 0), "bp.w2");
        step(mk(1, 0, 32'h204, 0, 1, 1, pkt, 4'b1111, 0), "bp.w3");
        for (int i = 0; i < 5; i++)
            step(mk(1, 0, 32'h55, 0, 0, 1, pkt, 4'b1111, 0), $sformatf("bp.hold%0d", i));
        step(mk(1, 0, 32'h55, 1, 1, 0, 128'h00000055, 4'b0001, 0), "bp.drain_acc");
        step(mk(1, 0, 32'h56, 1, 1, 0, 128'h00000056_00000055, 4'b0011, 0), "bp.n1");
        step(mk(1, 0, 32'h57, 1, 1, 0, 128'h00000057_00000056_00000055, 4'b0111, 0), "bp.n2");
        step(mk(1, 0, 32'h58, 1, 1, 1, 128'h00000058_00000057_00000056_00000055, 4'b1111, 0), "bp.n3");
        step(idle, "bp.idle");

        // Reset mid-packet discards the partial packet.
        step(mk(1, 0, 32'h301, 1, 1, 0, 128'h00000301, 4'b0001, 0), "rst.w0");
        step(mk(1, 0, 32'h302, 1, 1, 0, 128'h00000302_00000301, 4'b0011, 0), "rst.w1");
        @(negedge clk);
        bus.data_i_valid = 1'b0;
        bus.data_i_last  = 1'b0;
        nreset_i         = 1'b0;
        #1;
        check_reset_values("rst.mid");
        @(posedge clk);
        @(negedge clk);
        nreset_i = 1'b1;
        step(mk(1, 0, 32'h401, 1, 1, 0, 128'h00000401, 4'b0001, 0), "rst.f0");
        step(mk(1, 0, 32'h402, 1, 1, 0, 128'h00000402_00000401, 4'b0011, 0), "rst.f1");
        step(mk(1, 0, 32'h403, 1, 1, 0, 128'h00000403_00000402_00000401, 4'b0111, 0), "rst.f2");
        step(mk(1, 0, 32'h404, 1, 1, 1, 128'h00000404_00000403_00000402_00000401, 4'b1111, 0), "rst.f3");
        step(idle, "rst.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
